// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host receiver: synchronises and glitch-filters the pins, deframes
// 11-bit frames, checks odd parity and start/stop bits, and aborts stalled frames.
module ps2_rx_frame #(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2c,
    input  logic       ps2d,
    input  logic       rx_en,
    output logic [7:0] dout,
    output logic       rx_done_tick,
    output logic       parity_err,
    output logic       frame_err
);

    typedef enum logic [1:0] {StIdle, StShift, StDone, StAbort} state_e;

    localparam logic [16:0] TmoLast = 17'(TIMEOUT_CYC - 1);

    state_e                state_q, state_d;
    logic [1:0]            c_sync_q, d_sync_q;
    logic [FILTER_LEN-1:0] filt_sr_q;
    logic                  filt_clk_q, filt_clk_prev_q;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [16:0]           tmo_q, tmo_d;
    logic [10:0]           frame_q, frame_d, frame_shift;
    logic [7:0]            dout_q, dout_d;
    logic                  perr_q, perr_d, ferr_q, ferr_d;
    logic                  fall, bit_in;

    assign fall        = filt_clk_prev_q & ~filt_clk_q;
    assign bit_in      = d_sync_q[1];
    assign frame_shift = {bit_in, frame_q[10:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StIdle;
            c_sync_q        <= 2'b11;
            d_sync_q        <= 2'b11;
            filt_sr_q       <= '1;
            filt_clk_q      <= 1'b1;
            filt_clk_prev_q <= 1'b1;
            bit_cnt_q       <= '0;
            tmo_q           <= '0;
            frame_q         <= '0;
            dout_q          <= '0;
            perr_q          <= 1'b0;
            ferr_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            c_sync_q        <= {c_sync_q[0], ps2c};
            d_sync_q        <= {d_sync_q[0], ps2d};
            filt_sr_q       <= {filt_sr_q[FILTER_LEN-2:0], c_sync_q[1]};
            if (&filt_sr_q) begin
                filt_clk_q <= 1'b1;
            end else if (~|filt_sr_q) begin
                filt_clk_q <= 1'b0;
            end
            filt_clk_prev_q <= filt_clk_q;
            bit_cnt_q       <= bit_cnt_d;
            tmo_q           <= tmo_d;
            frame_q         <= frame_d;
            dout_q          <= dout_d;
            perr_q          <= perr_d;
            ferr_q          <= ferr_d;
        end
    end

    // Result registers are loaded on entry to DONE/ABORT so they are valid with the strobe.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        tmo_d     = tmo_q;
        frame_d   = frame_q;
        dout_d    = dout_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        unique case (state_q)
            StIdle: begin
                tmo_d = '0;
                if (fall && rx_en) begin
                    frame_d   = {bit_in, 10'b0};
                    bit_cnt_d = 4'd10;
                    state_d   = StShift;
                end
            end
            StShift: begin
                if (fall) begin
                    frame_d   = frame_shift;
                    bit_cnt_d = bit_cnt_q - 4'd1;
                    tmo_d     = '0;
                    if (bit_cnt_q == 4'd1) begin
                        state_d = StDone;
                        dout_d  = frame_shift[8:1];
                        perr_d  = ~^frame_shift[9:1];
                        ferr_d  = frame_shift[0] | ~frame_shift[10];
                    end
                end else if (tmo_q + 17'd1 >= TmoLast) begin
                    tmo_d   = TmoLast;
                    state_d = StAbort;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b1;
                end else begin
                    tmo_d = tmo_q + 17'd1;
                end
            end
            StDone, StAbort: begin
                tmo_d   = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign dout         = dout_q;
    assign parity_err   = perr_q;
    assign frame_err    = ferr_q;
    assign rx_done_tick = (state_q == StDone) || (state_q == StAbort);

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Directed bench for ps2_rx_frame with a scaled PS/2 clock and timeout.
module tb_ps2_rx_frame;

    localparam int unsigned FL   = 8;
    localparam int unsigned TMO  = 1000;
    localparam int unsigned HALF = 40;

    logic       clk = 1'b0;
    logic       reset, ps2c, ps2d, rx_en;
    logic [7:0] dout;
    logic       rx_done_tick, parity_err, frame_err;

    int         total = 0;
    int         bad = 0;
    int         double_cnt = 0;
    logic       done_prev = 1'b0;
    logic [9:0] cap_q[$];

    always #10 clk = ~clk;

    ps2_rx_frame #(.FILTER_LEN(FL), .TIMEOUT_CYC(TMO)) dut (
        .clk          (clk),
        .reset        (reset),
        .ps2c         (ps2c),
        .ps2d         (ps2d),
        .rx_en        (rx_en),
        .dout         (dout),
        .rx_done_tick (rx_done_tick),
        .parity_err   (parity_err),
        .frame_err    (frame_err)
    );

    // Captures {parity_err, frame_err, dout} on every strobe.
    always @(negedge clk) begin
        if (rx_done_tick) begin
            cap_q.push_back({parity_err, frame_err, dout});
            if (done_prev) double_cnt++;
        end
        done_prev = rx_done_tick;
    end

    initial begin
        #50_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ps2d = b;
        wait_cyc(HALF);
        ps2c = 1'b0;
        wait_cyc(HALF);
        ps2c = 1'b1;
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] data, input logic bad_par,
                                               input logic bad_stop);
        return {~bad_stop, (~^data) ^ bad_par, data, 1'b0};
    endfunction

    task automatic send_frame(input logic [7:0] data, input logic bad_par, input logic bad_stop,
                              input int drop_at);
        logic [10:0] bits;
        bits = frame_bits(data, bad_par, bad_stop);
        for (int i = 0; i < 11; i++) begin
            send_bit(bits[i]);
            if (i + 1 == drop_at) rx_en = 1'b0;
        end
        ps2d = 1'b1;
        wait_cyc(3 * HALF);
    endtask

    function automatic logic [9:0] cap_at(input int idx);
        return (cap_q.size() > idx) ? cap_q[idx] : 10'h3ff;
    endfunction

    task automatic test_reset();
        reset = 1'b1; ps2c = 1'b1; ps2d = 1'b1; rx_en = 1'b1;
        wait_cyc(5);
        total++; if (dout !== 8'h00) begin bad++; $display("FAIL reset_dout: got %h want 00", dout); end
        total++; if (rx_done_tick !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", rx_done_tick); end
        total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL reset_perr: got %b want 0", parity_err); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
        reset = 1'b0;
        wait_cyc(30);
        total++; if (cap_q.size() !== 0) begin bad++; $display("FAIL reset_idle_strobes: got %0d want 0", cap_q.size()); end
    endtask

    task automatic test_basic();
        cap_q.delete();
        send_frame(8'h1C, 1'b0, 1'b0, 0);
        total++; if (cap_q.size() !== 1) begin bad++; $display("FAIL basic_count: got %0d want 1", cap_q.size()); end
        total++; if (cap_at(0) !== 10'h01C) begin bad++; $display("FAIL basic_cap: got %h want 01c", cap_at(0)); end
        total++; if (dout !== 8'h1C) begin bad++; $display("FAIL basic_hold: got %h want 1c", dout); end
    endtask

    task automatic test_back_to_back();
        cap_q.delete();
        send_frame(8'hF0, 1'b0, 1'b0, 0);
        send_frame(8'h1C, 1'b0, 1'b0, 0);
        total++; if (cap_q.size() !== 2) begin bad++; $display("FAIL b2b_count: got %0d want 2", cap_q.size()); end
        total++; if (cap_at(0) !== 10'h0F0) begin bad++; $display("FAIL b2b_first: got %h want 0f0", cap_at(0)); end
        total++; if (cap_at(1) !== 10'h01C) begin bad++; $display("FAIL b2b_second: got %h want 01c", cap_at(1)); end
    endtask

    task automatic test_errors();
        cap_q.delete();
        send_frame(8'h1C, 1'b1, 1'b0, 0);
        send_frame(8'h1C, 1'b0, 1'b1, 0);
        total++; if (cap_q.size() !== 2) begin bad++; $display("FAIL err_count: got %0d want 2", cap_q.size()); end
        total++; if (cap_at(0) !== 10'h21C) begin bad++; $display("FAIL err_parity: got %h want 21c", cap_at(0)); end
        total++; if (cap_at(1) !== 10'h11C) begin bad++; $display("FAIL err_stop: got %h want 11c", cap_at(1)); end
        total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL err_ferr_hold: got %b want 1", frame_err); end
    endtask

    task automatic test_glitch();
        cap_q.delete();
        for (int g = 0; g < 3; g++) begin
            ps2c = 1'b0;
            wait_cyc(FL - 2);
            ps2c = 1'b1;
            wait_cyc(20);
        end
        total++; if (cap_q.size() !== 0) begin bad++; $display("FAIL glitch_spurious: got %0d want 0", cap_q.size()); end
        send_frame(8'h29, 1'b0, 1'b0, 0);
        total++; if (cap_q.size() !== 1) begin bad++; $display("FAIL glitch_count: got %0d want 1", cap_q.size()); end
        total++; if (cap_at(0) !== 10'h029) begin bad++; $display("FAIL glitch_cap: got %h want 029", cap_at(0)); end
    endtask

    task automatic test_rx_en();
        cap_q.delete();
        rx_en = 1'b0;
        send_frame(8'h1C, 1'b0, 1'b0, 0);
        total++; if (cap_q.size() !== 0) begin bad++; $display("FAIL rxen_off: got %0d want 0", cap_q.size()); end
        rx_en = 1'b1;
        send_frame(8'h1C, 1'b0, 1'b0, 3);
        total++; if (cap_q.size() !== 1) begin bad++; $display("FAIL rxen_drop_count: got %0d want 1", cap_q.size()); end
        total++; if (cap_at(0) !== 10'h01C) begin bad++; $display("FAIL rxen_drop_cap: got %h want 01c", cap_at(0)); end
        rx_en = 1'b1;
    endtask

    task automatic test_timeout();
        logic [10:0] bits;
        int          n;
        logic        got;
        cap_q.delete();
        bits = frame_bits(8'h1C, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(bits[i]);
        ps2d = bits[4];
        wait_cyc(HALF);
        ps2c = 1'b0;
        n = 0;
        got = 1'b0;
        while (n < 3 * TMO && !got) begin
            @(posedge clk);
            #1;
            n++;
            if (n == HALF) ps2c = 1'b1;
            if (rx_done_tick) got = 1'b1;
        end
        ps2c = 1'b1;
        ps2d = 1'b1;
        total++; if (n !== FL + 3 + TMO) begin bad++; $display("FAIL tmo_latency: got %0d want %0d", n, FL + 3 + TMO); end
        wait_cyc(3 * HALF);
        total++; if (cap_q.size() !== 1) begin bad++; $display("FAIL tmo_count: got %0d want 1", cap_q.size()); end
        total++; if (cap_at(0) !== 10'h11C) begin bad++; $display("FAIL tmo_cap: got %h want 11c", cap_at(0)); end
        total++; if (double_cnt !== 0) begin bad++; $display("FAIL strobe_width: got %0d long strobes want 0", double_cnt); end
        send_frame(8'h1C, 1'b0, 1'b0, 0);
        total++; if (cap_at(1) !== 10'h01C) begin bad++; $display("FAIL tmo_recover: got %h want 01c", cap_at(1)); end
    endtask

    task automatic test_reset_mid();
        logic [10:0] bits;
        cap_q.delete();
        bits = frame_bits(8'h1C, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(bits[i]);
        ps2d = bits[5];
        wait_cyc(HALF);
        ps2c = 1'b0;
        wait_cyc(FL + 6);
        reset = 1'b1;
        wait_cyc(HALF - FL - 6);
        ps2c = 1'b1;
        ps2d = 1'b1;
        wait_cyc(FL + 6);
        reset = 1'b0;
        wait_cyc(2 * TMO);
        total++; if (cap_q.size() !== 0) begin bad++; $display("FAIL rstmid_strobes: got %0d want 0", cap_q.size()); end
        total++; if (dout !== 8'h00) begin bad++; $display("FAIL rstmid_dout: got %h want 00", dout); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL rstmid_ferr: got %b want 0", frame_err); end
        total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL rstmid_perr: got %b want 0", parity_err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_errors();
        test_glitch();
        test_rx_en();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
